uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin, packet-granular arbiter that shares one `uart_tx` serializer between `NUM_REQ` byte-stream requesters.
- Each requester offers bytes over a valid/ready handshake, with a `last` flag marking the final byte of a packet.
- The arbiter locks the serializer to one requester until that packet's last byte is sent.
- It sequences the serializer's `tx_din`/`tx_start` inputs and waits on `tx_done_tick` between bytes.
- It sits between the protocol/command blocks and the `uart_tx` instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters (1 to 16).
- `IDLE_GAP`, default 0: idle clock cycles inserted after each packet, before the next arbitration.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is asynchronous and active-high.
- `req_valid_i` in NUM_REQ: requester k has a byte available.
- `req_data_i` in 8*NUM_REQ: byte of requester k, at bits [8k+7:8k].
- `req_last_i` in NUM_REQ: requester k's current byte is the last byte of its packet.
- `req_ready_o` out NUM_REQ: byte of requester k accepted this cycle when it coincides with valid.
- `grant_o` out NUM_REQ: one-hot current packet owner; all zero when no owner.
- `tx_din_o` out 8: byte to `uart_tx`.
- `tx_start_o` out 1: one-cycle start pulse to `uart_tx`.
- `tx_done_tick_i` in 1: byte-complete pulse from `uart_tx`.
- `tx_active_i` in 1: `uart_tx` busy.
- `busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ACCEPT, START, WAIT, GAP.
- **IDLE**
  - Arbitration runs only when `tx_active_i`=0 and any `req_valid_i` bit is high.
  - The winner is the first valid index searching upward (with wrap) from `ptr+1`.
  - Winner is registered into owner/`grant_o`; next state is ACCEPT.
  - Otherwise the FSM stays in IDLE.
- **ACCEPT**
  - `req_ready_o[owner]`=1; it is decoded combinationally from state and owner.
  - On `req_valid_i[owner]`=1, latch `req_data_i[owner]` into `tx_din_o` and `req_last_i[owner]` into `last_q`, then go to START.
  - Otherwise stay in ACCEPT. There is no timeout: the owner keeps the lock until it delivers its last byte.
  - Other requesters' valids are ignored while a packet is owned.
- **START**: `tx_start_o`=1 for exactly this cycle, then go to WAIT.
- **WAIT**
  - Hold `tx_din_o` stable.
  - On `tx_done_tick_i`=1:
    - if `last_q`=0, go to ACCEPT (same owner);
    - if `last_q`=1, set `ptr`=owner, clear `grant_o`, and go to GAP (or straight to IDLE if `IDLE_GAP`=0).
- **GAP**: count `IDLE_GAP` cycles (counter width `$clog2(IDLE_GAP+1)`), then go to IDLE.
- `tx_done_tick_i` outside WAIT is ignored.
- A single-byte packet (`last`=1 on the first byte) is legal.
- If the previous owner is the only requester, it wins again.

## Timing
- Reset values: state IDLE, `ptr`=NUM_REQ-1 (so requester 0 has first priority), `grant_o`=0, `req_ready_o`=0, `tx_din_o`=8'h00, `tx_start_o`=0, `busy_o`=0, `last_q`=0, gap counter 0.
- Latency, with a valid request in IDLE at cycle 0:
  - cycle 1: ACCEPT, ready high, handshake completes;
  - cycle 2: `tx_start_o`=1, `tx_din_o` valid;
  - WAIT from cycle 3.
- Between bytes of a packet: `tx_done_tick_i` at cycle n gives ACCEPT at n+1 and the next `tx_start_o` at n+2 at the earliest.
- Reset mid-packet: all state and outputs return to their reset values asynchronously. No byte is replayed, and the owner's handshake is dropped.
- `grant_o` is high from ACCEPT through WAIT of the last byte, and low in GAP and IDLE.
- `NUM_REQ`=1: arbitration degenerates to always granting index 0.

## Test plan
- Reset and single requester: req0 sends 2-byte packet 8'h51 then 8'ha3 (last). Required: `tx_start_o` pulses twice, `tx_din_o` shows 8'h51 then 8'ha3, `grant_o`=4'b0001 throughout, `busy_o` low after the second done.
- Round-robin: all 4 requesters valid with 1-byte packets 8'h10..8'h13. Required: grant order 0,1,2,3; starting again after a new req2/req0 pair, the order is 0 then 2.
- Packet lock: req1 sends 3 bytes, with `req_valid_i[1]` low for 20 cycles between bytes 1 and 2, while req0 stays valid. Required: req0 is not granted until after req1's last `tx_done_tick_i`.
- Serializer busy: `tx_active_i`=1 with requests pending. Required: FSM stays in IDLE and no grant until `tx_active_i`=0.
- Gap: `IDLE_GAP`=5 with back-to-back packets. Required: exactly 5 cycles in GAP between the last done and the next ACCEPT.
- Async reset: assert `rst_i` in WAIT mid-packet. Required: all outputs reach reset values immediately (same cycle, no clock edge needed), and after release req0 wins first.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-granular arbiter in front of a single uart_tx serializer.
// One requester owns the serializer from its first byte until its last byte
// has been shifted out; ownership then rotates starting after the old owner.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no owner; arbitrate when the serializer is free and a request is up
// ACCEPT | ready to the owner, waiting for its next byte
// START  | one-cycle start pulse to uart_tx with the latched byte
// WAIT   | byte on the line; wait for tx_done_tick_i
// GAP    | post-packet quiet time of IDLE_GAP cycles before re-arbitrating
module uart_tx_arb #(
  parameter int NUM_REQ  = 4,
  parameter int IDLE_GAP = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [7:0]           tx_din_o,
  output logic                 tx_start_o,
  input  logic                 tx_done_tick_i,
  input  logic                 tx_active_i,
  output logic                 busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
  // Down-counter terminates at zero, so load one less than the gap length.
  localparam logic [GAP_W-1:0] GAP_LOAD = (IDLE_GAP > 0) ? GAP_W'(IDLE_GAP - 1) : '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_START,
    ST_WAIT,
    ST_GAP
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               last_q;
  logic [GAP_W-1:0]   gap_cnt_q;

  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   cand;
  logic               arb_go;

  logic [7:0]         req_bytes [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
    assign req_bytes[k] = req_data_i[8*k +: 8];
  end

  // Round-robin search: first valid index upward from ptr+1, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!arb_found && req_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign arb_go = !tx_active_i && arb_found;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (arb_go) state_d = ST_ACCEPT;
      ST_ACCEPT: if (req_valid_i[owner_q]) state_d = ST_START;
      ST_START:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done_tick_i) begin
          if (!last_q)           state_d = ST_ACCEPT;
          else if (IDLE_GAP > 0) state_d = ST_GAP;
          else                   state_d = ST_IDLE;
        end
      end
      ST_GAP:    if (gap_cnt_q == '0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Ready goes only to the owner, and only while a byte is being accepted.
  always_comb begin
    req_ready_o = '0;
    if (state_q == ST_ACCEPT) req_ready_o[owner_q] = 1'b1;
  end

  assign tx_start_o = (state_q == ST_START);
  assign busy_o     = (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Owner, pointer, byte latch and gap timer updates keyed off the current state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q   <= '0;
      ptr_q     <= PTR_RST;
      grant_o   <= '0;
      tx_din_o  <= 8'h00;
      last_q    <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_go) begin
            owner_q <= arb_idx;
            grant_o <= NUM_REQ'(1) << arb_idx;
          end
        end
        ST_ACCEPT: begin
          if (req_valid_i[owner_q]) begin
            tx_din_o <= req_bytes[owner_q];
            last_q   <= req_last_i[owner_q];
          end
        end
        ST_WAIT: begin
          if (tx_done_tick_i && last_q) begin
            ptr_q     <= owner_q;
            grant_o   <= '0;
            gap_cnt_q <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queued requester models, a uart_tx stand-in that
// checks each started byte against an expected-order scoreboard, and a
// directed sequence of scenarios in one initial block.
module tb_uart_tx_arb;

  localparam int NR  = 4;
  localparam int GAP = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   grant;
  logic [7:0]      tx_din;
  logic            tx_start;
  logic            tx_done;
  logic            tx_active;
  logic            busy;
  logic            mock_busy;
  logic            force_active;

  assign tx_active = mock_busy | force_active;

  always #5 clk = ~clk;

  uart_tx_arb #(.NUM_REQ(NR), .IDLE_GAP(GAP)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_last_i     (req_last),
    .req_ready_o    (req_ready),
    .grant_o        (grant),
    .tx_din_o       (tx_din),
    .tx_start_o     (tx_start),
    .tx_done_tick_i (tx_done),
    .tx_active_i    (tx_active),
    .busy_o         (busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] gap;
  } ent_t;

  typedef struct packed {
    logic [NR-1:0] grant;
    logic [7:0]    data;
  } exp_t;

  ent_t rq [NR][$];
  exp_t sb [$];
  int   stall [NR];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input int k, input logic [7:0] d, input logic l, input logic [7:0] g);
    ent_t e;
    e.data = d;
    e.last = l;
    e.gap  = g;
    rq[k].push_back(e);
  endtask

  task automatic push_exp(input int k, input logic [7:0] d);
    exp_t e;
    e.grant = NR'(32'd1 << k);
    e.data  = d;
    sb.push_back(e);
  endtask

  function automatic logic rq_pending();
    logic p = 1'b0;
    for (int k = 0; k < NR; k++) if (rq[k].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string tag);
    int t = 0;
    while ((sb.size() != 0 || busy || rq_pending()) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(t < 2000), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!tx_done && t < 200);
    chk(tag, 32'(tx_done), 32'd1);
  endtask

  // Counts GAP cycles between a last-byte done and the next ACCEPT.
  task automatic measure_gap(input string tag);
    int n = 0;
    int t = 0;
    wait_done({tag, "_done"});
    do begin
      @(negedge clk);
      t++;
      if (busy && grant == '0 && req_ready == '0 && !tx_start) n++;
    end while (req_ready == '0 && t < 40);
    chk(tag, 32'(n), 32'(GAP));
  endtask

  // Requester models: present queue heads, pop on completed handshakes.
  initial begin : requesters
    logic [NR-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (acc[k] && !rst && rq[k].size() > 0) begin
          void'(rq[k].pop_front());
          if (rq[k].size() > 0) stall[k] = int'(rq[k][0].gap);
        end
        if (stall[k] > 0) begin
          stall[k]--;
          req_valid[k] = 1'b0;
        end else if (rq[k].size() > 0) begin
          req_valid[k]      = 1'b1;
          req_data[8*k +: 8] = rq[k][0].data;
          req_last[k]       = rq[k][0].last;
        end else begin
          req_valid[k] = 1'b0;
        end
      end
    end
  end

  // uart_tx stand-in: checks each started byte, holds busy, returns a done tick.
  initial begin : serializer
    exp_t       e;
    logic [7:0] held;
    tx_done   = 1'b0;
    mock_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("tx_din", 32'(tx_din), 32'(e.data));
          chk("grant_at_start", 32'(grant), 32'(e.grant));
        end
        held      = tx_din;
        mock_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (rst) break;
        end
        if (!rst) begin
          chk("tx_din_hold", 32'(tx_din), 32'(held));
          @(posedge clk);
          #1 tx_done = 1'b1;
          @(posedge clk);
          #1 tx_done = 1'b0;
        end
        mock_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int t;
    int viol;
    rst          = 1'b1;
    force_active = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_din",   32'(tx_din), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin across all four with single-byte packets; gap after each.
    for (int k = 0; k < NR; k++) begin
      push_req(k, 8'(8'h10 + k), 1'b1, 8'd0);
      push_exp(k, 8'(8'h10 + k));
    end
    measure_gap("rr_gap0");
    measure_gap("rr_gap1");
    measure_gap("rr_gap2");
    measure_gap("rr_gap3");
    drain("rr_drain");

    // New req2/req0 pair after owner 3: 0 then 2.
    push_req(2, 8'h22, 1'b1, 8'd0);
    push_req(0, 8'h20, 1'b1, 8'd0);
    push_exp(0, 8'h20);
    push_exp(2, 8'h22);
    drain("pair_drain");

    // Single requester, two-byte packet, with cycle-exact latency.
    push_req(0, 8'h51, 1'b0, 8'd0);
    push_req(0, 8'ha3, 1'b1, 8'd0);
    push_exp(0, 8'h51);
    push_exp(0, 8'ha3);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_valid[0] && t < 20);
    chk("lat_c0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("lat_c1_ready", 32'(req_ready), 32'h1);
    chk("lat_c1_grant", 32'(grant), 32'h1);
    @(negedge clk);
    chk("lat_c2_start", 32'(tx_start), 32'd1);
    chk("lat_c2_din", 32'(tx_din), 32'h51);
    wait_done("b1_done");
    @(negedge clk);
    chk("b2_accept", 32'(req_ready), 32'h1);
    chk("b2_grant", 32'(grant), 32'h1);
    @(negedge clk);
    chk("b2_start", 32'(tx_start), 32'd1);
    chk("b2_din", 32'(tx_din), 32'ha3);
    wait_done("b2_done");
    @(negedge clk);
    chk("gap_grant_low", 32'(grant), 32'd0);
    drain("single_drain");
    chk("single_busy_low", 32'(busy), 32'd0);

    // Serializer busy holds off arbitration.
    force_active = 1'b1;
    push_req(3, 8'h33, 1'b1, 8'd0);
    push_req(1, 8'h31, 1'b1, 8'd0);
    push_exp(1, 8'h31);
    push_exp(3, 8'h33);
    viol = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || grant != '0) viol++;
    end
    chk("active_hold", 32'(viol), 32'd0);
    force_active = 1'b0;
    drain("active_drain");

    // Packet lock: req1 stalls mid-packet while req0 waits.
    push_req(1, 8'h61, 1'b0, 8'd0);
    push_req(1, 8'h62, 1'b0, 8'd20);
    push_req(1, 8'h63, 1'b1, 8'd0);
    push_exp(1, 8'h61);
    push_exp(1, 8'h62);
    push_exp(1, 8'h63);
    push_exp(0, 8'h70);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (grant != 4'b0010 && t < 50);
    chk("lock_granted", 32'(grant), 32'h2);
    push_req(0, 8'h70, 1'b1, 8'd0);
    viol = 0;
    repeat (15) begin
      @(negedge clk);
      if (grant[0] || req_ready[0]) viol++;
    end
    chk("lock_hold", 32'(viol), 32'd0);
    chk("lock_owner", 32'(grant), 32'h2);
    drain("lock_drain");

    // Async reset in WAIT mid-packet.
    push_req(2, 8'ha1, 1'b0, 8'd0);
    push_req(2, 8'ha2, 1'b1, 8'd0);
    push_exp(2, 8'ha1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mock_busy && t < 50);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_grant", 32'(grant), 32'h4);
    rst = 1'b1;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_din",   32'(tx_din), 32'd0);
    chk("arst_start", 32'(tx_start), 32'd0);
    chk("arst_busy",  32'(busy), 32'd0);
    sb.delete();
    push_req(0, 8'hb0, 1'b1, 8'd0);
    push_exp(0, 8'hb0);
    push_exp(2, 8'ha2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drain("arst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
